// File: rtl/raster_tri_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raster_tri_scheduler_pkg
//  Description : Shared rasterizer definitions: payload/tag width helpers and
//                the triangle scheduler state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package raster_tri_scheduler_pkg;

    // Scheduler phases: waiting for work, feeding the core, waiting for idle
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Triangle payload: 9 position words plus 3 vertices x (N_ATTR-1) attributes
    function automatic int tri_w(input int n_attr, input int data_width);
        return (9 + 3 * (n_attr - 1)) * data_width;
    endfunction

    // Requester index width, never narrower than one bit
    function automatic int tag_w(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_rr_arbiter
//  Description : Combinational round-robin picker. Returns the first asserted
//                request strictly after last_owner, wrapping through index 0;
//                last_owner itself has the lowest priority.
//  Revision    : 1.0  initial release
// ============================================================================
module raster_rr_arbiter
    import raster_tri_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = tag_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [TAG_W-1:0] last_owner,
    output logic             grant_valid,
    output logic [TAG_W-1:0] grant_idx
);

    // Index that is 'off' positions after 'base', modulo the requester count
    function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] base, input int off);
        return TAG_W'((int'(base) + off) % N_REQ);
    endfunction

    // Scan from the farthest candidate to the nearest so the nearest one wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[wrap_idx(last_owner, k)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap_idx(last_owner, k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/raster_tri_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : raster_tri_scheduler
//  Description : Time-shares one rasterizer core among N_REQ triangle sources.
//                A requester is granted round-robin, may issue up to BURST
//                triangles, then the core is drained (DRAIN_CYCLES idle cycles)
//                before the next grant so every fragment carries its owner tag.
//  Revision    : 1.0  initial release
// ============================================================================
module raster_tri_scheduler
    import raster_tri_scheduler_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int N_ATTR       = 4,
    parameter int BURST        = 8,
    parameter int DRAIN_CYCLES = 4,
    // Derived widths; leave at their defaults
    parameter int TRI_W        = tri_w(N_ATTR, DATA_WIDTH),
    parameter int TAG_W        = tag_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_tri_valid,
    output logic [N_REQ-1:0]       req_tri_ready,
    input  logic [N_REQ*TRI_W-1:0] req_tri_data,
    output logic                   core_tri_valid,
    input  logic                   core_tri_ready,
    output logic [TRI_W-1:0]       core_tri_data,
    input  logic                   core_done,
    input  logic                   core_frag_valid,
    output logic                   core_frag_ready,
    output logic                   frag_valid,
    input  logic                   frag_ready,
    output logic [TAG_W-1:0]       frag_tag,
    output logic                   busy
);

    localparam int c_BURST_W = $clog2(BURST + 1);
    localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [c_BURST_W-1:0] c_BURST_MAX  = c_BURST_W'(BURST);
    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(BURST - 1);
    localparam logic [c_BURST_W-1:0] c_BURST_ONE  = c_BURST_W'(1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
    localparam logic [TAG_W-1:0]     c_LAST_RST   = TAG_W'(N_REQ - 1);

    sched_state_t           r_state;
    logic [TAG_W-1:0]       r_owner;
    logic [TAG_W-1:0]       r_last_owner;
    logic [c_BURST_W-1:0]   r_burst_cnt;
    logic [c_DRAIN_W-1:0]   r_drain_cnt;
    logic                   r_core_tri_valid;
    logic [TRI_W-1:0]       r_core_tri_data;
    logic                   r_busy;

    logic                   w_grant_valid;
    logic [TAG_W-1:0]       w_grant_idx;
    logic                   w_slot_free;
    logic                   w_can_take;
    logic                   w_owner_valid;
    logic                   w_tri_hs;
    logic                   w_drain_idle;
    logic [TRI_W-1:0]       w_slices [N_REQ];
    logic [TRI_W-1:0]       w_owner_data;

    raster_rr_arbiter #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_arbiter (
        .req         (req_tri_valid),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    // The output slot can take a new triangle if empty or emptying this cycle
    assign w_slot_free   = !r_core_tri_valid || core_tri_ready;
    assign w_can_take    = (r_state == ST_ISSUE) && w_slot_free && (r_burst_cnt < c_BURST_MAX);
    assign w_owner_valid = req_tri_valid[r_owner];
    assign w_tri_hs      = w_can_take && w_owner_valid;
    assign w_owner_data  = w_slices[r_owner];

    // Core is quiet: nothing queued to it, backend idle, no fragment pending
    assign w_drain_idle  = !r_core_tri_valid && core_done && !core_frag_valid;

    // Per-requester payload slices and ready, only the owner is ever ready
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign w_slices[gi]      = req_tri_data[gi*TRI_W +: TRI_W];
        assign req_tri_ready[gi] = w_can_take && (r_owner == TAG_W'(gi));
    end

    // Scheduler FSM together with the registered triangle slot toward the core
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_owner          <= '0;
            r_last_owner     <= c_LAST_RST;
            r_burst_cnt      <= '0;
            r_drain_cnt      <= '0;
            r_core_tri_valid <= 1'b0;
            r_core_tri_data  <= '0;
            r_busy           <= 1'b0;
        end else begin
            // A load in the same cycle as a core accept keeps valid high
            if (w_tri_hs) begin
                r_core_tri_valid <= 1'b1;
                r_core_tri_data  <= w_owner_data;
            end else if (core_tri_ready) begin
                r_core_tri_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant_idx;
                        r_burst_cnt <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= ST_ISSUE;
                        r_busy      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (w_tri_hs) begin
                        r_burst_cnt <= r_burst_cnt + c_BURST_ONE;
                    end
                    // Burst exhausted, or owner had a free slot but nothing to send
                    if ((w_tri_hs && (r_burst_cnt == c_BURST_LAST)) ||
                        (w_can_take && !w_owner_valid)) begin
                        r_drain_cnt <= '0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_drain_idle) begin
                        if (r_drain_cnt == c_DRAIN_LAST) begin
                            r_drain_cnt  <= '0;
                            r_last_owner <= r_owner;
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + c_DRAIN_ONE;
                        end
                    end else begin
                        r_drain_cnt <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Fragments pass straight through, tagged with the current owner
    assign frag_valid      = core_frag_valid;
    assign core_frag_ready = frag_ready;
    assign frag_tag        = r_owner;

    assign core_tri_valid  = r_core_tri_valid;
    assign core_tri_data   = r_core_tri_data;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_raster_tri_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raster_tri_scheduler
//  Description : Directed self-checking bench for raster_tri_scheduler with a
//                scoreboard of expected core triangles in arbitration order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_raster_tri_scheduler;

    localparam int N_REQ  = 4;
    localparam int DW     = 8;
    localparam int NA     = 4;
    localparam int BURST  = 2;
    localparam int DRAIN  = 4;
    localparam int TRI_W  = raster_tri_scheduler_pkg::tri_w(NA, DW);
    localparam int TAG_W  = raster_tri_scheduler_pkg::tag_w(N_REQ);
    localparam int DEPTH  = 16;

    typedef logic [TRI_W-1:0] tw_t;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_tri_valid;
    logic [N_REQ-1:0]       req_tri_ready;
    logic [N_REQ*TRI_W-1:0] req_tri_data;
    logic                   core_tri_valid;
    logic                   core_tri_ready;
    logic [TRI_W-1:0]       core_tri_data;
    logic                   core_done;
    logic                   core_frag_valid;
    logic                   core_frag_ready;
    logic                   frag_valid;
    logic                   frag_ready;
    logic [TAG_W-1:0]       frag_tag;
    logic                   busy;

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_core_xfers = 0;

    tw_t src_mem [N_REQ][DEPTH];
    int  src_cnt [N_REQ] = '{default: 0};
    int  src_head[N_REQ] = '{default: 0};
    tw_t exp_q[$];

    logic             lat_pend = 1'b0;
    tw_t              lat_data;
    logic             frag_chk = 1'b0;
    logic [TAG_W-1:0] exp_tag  = '0;

    raster_tri_scheduler #(
        .N_REQ        (N_REQ),
        .DATA_WIDTH   (DW),
        .N_ATTR       (NA),
        .BURST        (BURST),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_tri_valid   (req_tri_valid),
        .req_tri_ready   (req_tri_ready),
        .req_tri_data    (req_tri_data),
        .core_tri_valid  (core_tri_valid),
        .core_tri_ready  (core_tri_ready),
        .core_tri_data   (core_tri_data),
        .core_done       (core_done),
        .core_frag_valid (core_frag_valid),
        .core_frag_ready (core_frag_ready),
        .frag_valid      (frag_valid),
        .frag_ready      (frag_ready),
        .frag_tag        (frag_tag),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input tw_t obs, input tw_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Distinct payload per requester/sequence number, never zero or all-ones
    function automatic tw_t mk_tri(input int r, input int s);
        tw_t v;
        v = '0;
        for (int k = 0; k < TRI_W / 16; k++) begin
            v[k*16 +: 16] = {8'(r), 8'(s)} ^ 16'(k * 257);
        end
        return v;
    endfunction

    task automatic add_src(input int r, input int s);
        src_mem[r][src_cnt[r]] = mk_tri(r, s);
        src_cnt[r]++;
    endtask

    task automatic push_exp(input int r, input int s);
        exp_q.push_back(mk_tri(r, s));
    endtask

    function automatic bit all_consumed();
        for (int i = 0; i < N_REQ; i++) begin
            if (src_head[i] < src_cnt[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        logic f;
        f = 1'b0;
        for (int k = 0; k < 400; k++) begin
            step(1);
            if (!busy && all_consumed() && exp_q.size() == 0) begin
                f = 1'b1;
                break;
            end
        end
        check(tag, tw_t'(f), tw_t'(1'b1));
    endtask

    task automatic wait_core_valid(input string tag);
        logic f;
        f = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (core_tri_valid) begin
                f = 1'b1;
                break;
            end
        end
        check(tag, tw_t'(f), tw_t'(1'b1));
    endtask

    task automatic wait_busy(input string tag);
        logic f;
        f = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (busy) begin
                f = 1'b1;
                break;
            end
        end
        check(tag, tw_t'(f), tw_t'(1'b1));
    endtask

    // Requester models: present queue heads, advance on sampled handshakes
    initial begin : p_driver
        logic [N_REQ-1:0] v_hs;
        logic             v_rst;
        req_tri_valid = '0;
        req_tri_data  = '0;
        forever begin
            @(negedge clk);
            v_hs  = req_tri_valid & req_tri_ready;
            v_rst = rst;
            @(posedge clk);
            #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (v_hs[i] && !v_rst) src_head[i]++;
                if (src_head[i] < src_cnt[i]) begin
                    req_tri_valid[i]                = 1'b1;
                    req_tri_data[i*TRI_W +: TRI_W]  = src_mem[i][src_head[i]];
                end else begin
                    req_tri_valid[i]                = 1'b0;
                    req_tri_data[i*TRI_W +: TRI_W]  = '0;
                end
            end
        end
    end

    // Mid-cycle monitor: latency, scoreboard, ready ownership, fragment path
    initial begin : p_monitor
        tw_t              v_exp;
        logic [N_REQ-1:0] v_hs;
        forever begin
            @(negedge clk);
            if (lat_pend) begin
                check("latency_valid", tw_t'(core_tri_valid), tw_t'(1'b1));
                check("latency_data", core_tri_data, lat_data);
                lat_pend = 1'b0;
            end
            v_hs = req_tri_valid & req_tri_ready;
            if (!rst) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (v_hs[i]) begin
                        lat_pend = 1'b1;
                        lat_data = req_tri_data[i*TRI_W +: TRI_W];
                    end
                end
            end
            if (core_tri_valid && core_tri_ready && !rst) begin
                n_core_xfers++;
                if (exp_q.size() > 0) v_exp = exp_q.pop_front();
                else                  v_exp = '1;
                check("core_data", core_tri_data, v_exp);
            end
            if (req_tri_ready != '0) begin
                check("ready_owner", tw_t'(req_tri_ready), tw_t'(N_REQ'(1) << frag_tag));
            end
            if (frag_chk) begin
                check("frag_valid_pass", tw_t'(frag_valid), tw_t'(core_frag_valid));
                check("frag_ready_mirror", tw_t'(core_frag_ready), tw_t'(frag_ready));
                if (frag_valid) check("frag_tag", tw_t'(frag_tag), tw_t'(exp_tag));
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int x0;
        rst             = 1'b1;
        core_tri_ready  = 1'b0;
        core_done       = 1'b1;
        core_frag_valid = 1'b0;
        frag_ready      = 1'b0;
        step(3);

        // Reset values
        check("rst_core_valid", tw_t'(core_tri_valid), tw_t'(1'b0));
        check("rst_core_data", core_tri_data, tw_t'(0));
        check("rst_req_ready", tw_t'(req_tri_ready), tw_t'(0));
        check("rst_busy", tw_t'(busy), tw_t'(1'b0));
        check("rst_frag_tag", tw_t'(frag_tag), tw_t'(0));
        rst = 1'b0;

        // Requester 0 alone, three triangles, core always ready
        core_tri_ready = 1'b1;
        x0 = n_core_xfers;
        for (int s = 1; s <= 3; s++) begin
            push_exp(0, s);
            add_src(0, s);
        end
        wait_idle("t1_idle");
        check("t1_xfers", tw_t'(n_core_xfers - x0), tw_t'(3));

        // All four continuously valid from reset: 0,1,2,3,0,... two each
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        x0 = n_core_xfers;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_REQ; i++)
                for (int b = 0; b < BURST; b++)
                    push_exp(i, 10 + 2*r + b);
        for (int i = 0; i < N_REQ; i++)
            for (int s = 0; s < 4; s++)
                add_src(i, 10 + s);
        wait_idle("t2_idle");
        check("t2_xfers", tw_t'(n_core_xfers - x0), tw_t'(16));

        // Core stalls for five cycles with the owner still valid
        core_tri_ready = 1'b0;
        x0 = n_core_xfers;
        push_exp(1, 1);
        push_exp(1, 2);
        add_src(1, 1);
        add_src(1, 2);
        wait_core_valid("t3_valid");
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", tw_t'(core_tri_valid), tw_t'(1'b1));
            check("t3_hold_data", core_tri_data, mk_tri(1, 1));
            check("t3_hold_ready", tw_t'(req_tri_ready), tw_t'(0));
            step(1);
        end
        core_tri_ready = 1'b1;
        wait_idle("t3_idle");
        check("t3_xfers", tw_t'(n_core_xfers - x0), tw_t'(2));

        // Fragments from owner 2 with downstream ready toggling
        exp_tag = 2'd2;
        push_exp(2, 1);
        push_exp(2, 2);
        add_src(2, 1);
        add_src(2, 2);
        frag_chk = 1'b1;
        wait_busy("t4_busy");
        for (int k = 0; k < 12; k++) begin
            core_frag_valid = (k % 3 != 2);
            frag_ready      = k[0];
            step(1);
        end
        core_frag_valid = 1'b0;
        frag_ready      = 1'b0;
        wait_idle("t4_idle");
        frag_chk = 1'b0;

        // core_done drops on the third DRAIN cycle: drain count restarts
        push_exp(3, 1);
        add_src(3, 1);
        wait_core_valid("t5_valid");
        step(3);
        core_done = 1'b0;
        step(1);
        core_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t5_busy_hold", tw_t'(busy), tw_t'(1'b1));
            step(1);
        end
        check("t5_idle", tw_t'(busy), tw_t'(1'b0));

        // Reset while issuing with a triangle held toward the core
        core_tri_ready = 1'b0;
        for (int s = 20; s < 23; s++) add_src(0, s);
        wait_core_valid("t6_valid");
        rst = 1'b1;
        step(1);
        check("t6_core_valid", tw_t'(core_tri_valid), tw_t'(1'b0));
        check("t6_core_data", core_tri_data, tw_t'(0));
        check("t6_req_ready", tw_t'(req_tri_ready), tw_t'(0));
        check("t6_busy", tw_t'(busy), tw_t'(1'b0));
        check("t6_frag_tag", tw_t'(frag_tag), tw_t'(0));
        src_cnt[0] = src_head[0];
        step(1);
        rst = 1'b0;
        step(2);

        check("final_queue_empty", tw_t'(exp_q.size()), tw_t'(0));
        check("total_xfers", tw_t'(n_core_xfers), tw_t'(24));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
